dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Handshaked data-memory target. It serves 64-bit doubleword load/store requests that the pipelined core's MEM stage issues as initiator.
- It replaces the zero-wait combinational data memory so that a multi-cycle memory can stall the pipeline.
- It accepts one request at a time, inserts a programmable number of wait states, then returns read data or a write acknowledge on a response channel with backpressure.

Parameters:
- DEPTH, 1024, number of 64-bit words stored; must be a power of two.
- LATENCY, 2, wait-state cycles between request acceptance and commit; legal range 0..15.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low; 0 resets control state immediately.
- req_valid, input, 1, initiator presents a request.
- req_ready, output, 1, responder can accept a request.
- req_write, input, 1, 1 = store, 0 = load.
- req_addr, input, 64, byte address.
- req_wdata, input, 64, store data.
- rsp_valid, output, 1, response available.
- rsp_ready, input, 1, initiator consumes the response.
- rsp_rdata, output, 64, load data; 0 for stores and for errors.
- rsp_error, output, 1, request was misaligned or out of range.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low on port `reset`. When reset = 0: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, wait counter = 0.
- Storage is not cleared by reset. Contents persist across reset.
- Request fields are sampled only on the handshake edge.
- Addressing:
  - word index = req_addr[log2(DEPTH)+2 : 3].
  - Error if req_addr[2:0] != 0, or if any of req_addr[63 : log2(DEPTH)+3] != 0.
  - An errored request performs no write and returns rsp_rdata = 0 with rsp_error = 1.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Handshake when req_valid & req_ready at edge E0. Capture write, addr, wdata and the error flag.
  - If LATENCY = 0: commit at E0 and go to RESP.
  - Otherwise: load counter = LATENCY - 1 and go to WAIT.
- WAIT:
  - req_ready = 0.
  - Decrement the counter each edge.
  - At the edge where counter == 0: commit and go to RESP.
  - Exactly LATENCY edges are spent in WAIT.
- Commit:
  - Store with no error: mem[index] <= wdata.
  - Load with no error: rsp_rdata <= mem[index].
  - Otherwise rsp_rdata <= 0.
  - rsp_error registered at the same edge.
- Latency: rsp_valid is first high in the cycle after edge E0+LATENCY.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_error held stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid falls, state returns to IDLE, and req_ready = 1 from the next cycle.
  - Responses are never dropped.
- No request is accepted in the same cycle as a response handshake. Peak throughput is one transaction per LATENCY + 2 cycles.
- Ordering: strictly one outstanding request. A load after a store to the same address returns the new data.
- Stores are acknowledged with a response: rsp_rdata = 0, rsp_error as computed.
- req_valid while not in IDLE is ignored. Request inputs may change freely outside the handshake edge.
- Reset mid-operation:
  - Reset during WAIT aborts the transaction; a store in WAIT is not written.
  - Reset during RESP discards the pending response; the write has already committed.
- Counter width is 4 bits. Wrap-around is not possible within the legal LATENCY range.

Test Plan:
- Store then load, LATENCY = 2:
  - Store addr 0x10, data 0xDEAD_BEEF_0123_4567 → rsp_valid 3 cycles after acceptance, rsp_rdata 0, rsp_error 0.
  - Load addr 0x10 → rsp_rdata 0xDEAD_BEEF_0123_4567.
- Backpressure: load with rsp_ready held 0 for 5 cycles → rsp_valid stays 1 with rsp_rdata stable; req_valid asserted during that time is not accepted (req_ready 0); the response completes on the first rsp_ready = 1 edge.
- Errors:
  - Load addr 0x13 → rsp_error 1, rsp_rdata 0.
  - Store addr 0x2000 (DEPTH 1024) → rsp_error 1; a later load of addr 0x0 still returns its prior value.
- LATENCY = 0 build: request accepted at edge E0 → rsp_valid high in the next cycle; back-to-back loads of addr 0x0/0x8 with rsp_ready = 1 complete every 2 cycles.
- Reset mid-WAIT: store 0x55 to addr 0x18 (holding 0x11), pull reset low during WAIT → outputs zero immediately, then load addr 0x18 returns 0x11.
- Boundary: store and load at the top word, addr 0x1FF8 (DEPTH 1024) → data round-trips, rsp_error 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Handshaked 64-bit data-memory target: one request at a time, LATENCY wait
// states, then a load-data / store-acknowledge response held until consumed.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never waits on ready, and a response stays put until taken.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [63:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [63:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_error_q, rsp_error_d;

  logic [63:0]     mem [DEPTH];

  logic            req_err;
  logic [AW-1:0]   req_idx;
  logic            commit;
  logic            c_write;
  logic [AW-1:0]   c_idx;
  logic [63:0]     c_wdata;
  logic            c_err;
  logic            mem_we;

  assign req_idx   = req_addr[AW+2:3];
  assign req_err   = (req_addr[2:0] != 3'b000) || (req_addr[63:AW+3] != '0);

  // Gated by reset so the initiator sees not-ready while reset is held.
  assign req_ready = reset && (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    commit      = 1'b0;
    c_write     = write_q;
    c_idx       = idx_q;
    c_wdata     = wdata_q;
    c_err       = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          idx_d   = req_idx;
          wdata_d = req_wdata;
          err_d   = req_err;
          if (LATENCY == 0) begin
            // Zero wait states: commit straight from the live request fields.
            commit  = 1'b1;
            c_write = req_write;
            c_idx   = req_idx;
            c_wdata = req_wdata;
            c_err   = req_err;
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      rsp_error_d = c_err;
      rsp_rdata_d = (!c_write && !c_err) ? mem[c_idx] : 64'h0;
    end
  end

  assign mem_we = commit && c_write && !c_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 64'h0;
      err_q       <= 1'b0;
      rsp_rdata_q <= 64'h0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Storage deliberately has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) mem[c_idx] <= c_wdata;
  end

endmodule
